// File: rtl/proc_io_hub_pkg.sv
// Shared helpers for the proc_* I/O hub: ceiling log2 and address-width derivation.
package proc_io_hub_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // A single channel still needs a one-bit select so the address ports never vanish.
  function automatic int addrWidth(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

// File: rtl/proc_io_hub_io_fifo.sv
// Single-clock FIFO for one input channel; the popped word is registered on o_rdata.
module io_fifo
  import proc_io_hub_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [NUBITS-1:0] i_pushData,
  input  logic              i_pop,
  output logic [NUBITS-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PW = clog2(FDEPTH);
  localparam int CW = PW + 1;

  logic [NUBITS-1:0] r_mem [FDEPTH];
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic [NUBITS-1:0] r_rdata;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full   = (r_count == CW'(FDEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_rdata  = r_rdata;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally because FDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_rdata <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
        r_rdata <= r_mem[r_rdPtr];
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/proc_io_hub.sv
// Processor I/O hub: buffered input channels, single-entry output holding registers,
// stall generation, maskable input-pending interrupt and sticky address-error flag.
module proc_io_hub
  import proc_io_hub_pkg::*;
#(
  parameter int                NUBITS = 32,
  parameter int                NUIOIN = 2,
  parameter int                NUIOOU = 2,
  parameter int                FDEPTH = 4,
  parameter logic [NUIOIN-1:0] ITRMSK = '1,
  localparam int               AIW    = addrWidth(NUIOIN),
  localparam int               AOW    = addrWidth(NUIOOU)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  input  logic [AIW-1:0]           proc_addr_in,
  output logic [NUBITS-1:0]        proc_din,
  input  logic                     proc_out_en,
  input  logic [AOW-1:0]           proc_addr_out,
  input  logic [NUBITS-1:0]        proc_dout,
  output logic                     proc_stall,
  output logic                     itr,
  output logic                     err,
  input  logic [NUIOIN*NUBITS-1:0] in_data,
  input  logic [NUIOIN-1:0]        in_vld,
  output logic [NUIOIN-1:0]        in_rdy,
  output logic [NUIOOU*NUBITS-1:0] out_data,
  output logic [NUIOOU-1:0]        out_vld,
  input  logic [NUIOOU-1:0]        out_rdy
);

  logic [NUIOIN*NUBITS-1:0] w_fifoRdata;
  logic [NUIOIN-1:0]        w_fifoFull;
  logic [NUIOIN-1:0]        w_fifoEmpty;
  logic [NUIOIN-1:0]        w_push;
  logic [NUIOIN-1:0]        w_pop;
  logic [NUIOIN-1:0]        w_rdHit;
  logic [NUIOOU-1:0]        w_wrHit;
  logic [NUIOOU-1:0]        w_load;
  logic                     w_rdInRange;
  logic                     w_wrInRange;
  logic                     w_rdEmpty;
  logic                     w_wrFull;
  logic                     w_stall;
  logic [NUBITS-1:0]        w_rdWord;

  logic [NUIOOU*NUBITS-1:0] r_outData;
  logic [NUIOOU-1:0]        r_outVld;
  logic                     r_itr;
  logic                     r_err;
  logic [AIW-1:0]           r_rdSel;
  logic                     r_rdZero;

  assign in_rdy = ~w_fifoFull & {NUIOIN{rst}};
  assign w_push = in_vld & in_rdy;

  genvar g;
  generate
    for (g = 0; g < NUIOIN; g++) begin : gen_fifo
      io_fifo #(
        .NUBITS (NUBITS),
        .FDEPTH (FDEPTH)
      ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push[g]),
        .i_pushData (in_data[g*NUBITS +: NUBITS]),
        .i_pop      (w_pop[g]),
        .o_rdata    (w_fifoRdata[g*NUBITS +: NUBITS]),
        .o_full     (w_fifoFull[g]),
        .o_empty    (w_fifoEmpty[g])
      );
    end
  endgenerate

  // A stall from either side blocks both accesses, so pop and load are gated by w_stall.
  always_comb begin
    w_rdHit = '0;
    w_wrHit = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (proc_addr_in == AIW'(i)) begin
        w_rdHit[i] = 1'b1;
      end
    end
    for (int j = 0; j < NUIOOU; j++) begin
      if (proc_addr_out == AOW'(j)) begin
        w_wrHit[j] = 1'b1;
      end
    end
    w_rdInRange = |w_rdHit;
    w_wrInRange = |w_wrHit;
    w_rdEmpty   = proc_req_in & |(w_rdHit & w_fifoEmpty);
    w_wrFull    = proc_out_en & |(w_wrHit & r_outVld & ~out_rdy);
    w_stall     = w_rdEmpty | w_wrFull;
    w_pop       = w_rdHit & ~w_fifoEmpty & {NUIOIN{proc_req_in & ~w_stall}};
    w_load      = w_wrHit & (~r_outVld | out_rdy) & {NUIOOU{proc_out_en & ~w_stall}};
  end

  always_comb begin
    w_rdWord = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (r_rdSel == AIW'(i)) begin
        w_rdWord = w_fifoRdata[i*NUBITS +: NUBITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_outVld  <= '0;
      r_outData <= '0;
      r_itr     <= 1'b0;
      r_err     <= 1'b0;
      r_rdSel   <= '0;
      r_rdZero  <= 1'b0;
    end else begin
      r_itr <= |(~w_fifoEmpty & ITRMSK);
      if ((proc_req_in & ~w_rdInRange) | (proc_out_en & ~w_wrInRange)) begin
        r_err <= 1'b1;
      end
      // Remember which FIFO feeds proc_din; an out-of-range read forces zero instead.
      if (proc_req_in & ~w_stall) begin
        r_rdZero <= ~w_rdInRange;
        if (w_rdInRange) begin
          r_rdSel <= proc_addr_in;
        end
      end
      for (int j = 0; j < NUIOOU; j++) begin
        if (w_load[j]) begin
          r_outVld[j]                    <= 1'b1;
          r_outData[j*NUBITS +: NUBITS]  <= proc_dout;
        end else if (r_outVld[j] & out_rdy[j]) begin
          r_outVld[j] <= 1'b0;
        end
      end
    end
  end

  assign proc_din   = r_rdZero ? '0 : w_rdWord;
  assign proc_stall = w_stall;
  assign itr        = r_itr;
  assign err        = r_err;
  assign out_vld    = r_outVld;
  assign out_data   = r_outData;

endmodule
